// File: rtl/b2b_event_arbiter.sv
// Event-granular round-robin arbiter: forwards whole events (header..footer) from one
// cluster FIFO at a time into a shared output-board FIFO, counting events and flagging errors.
module b2b_event_arbiter #(
    parameter int         DATA_WIDTH     = 65,
    parameter int         TOTAL_CLUSTERS = 4,
    parameter logic [7:0] HEADER_MARKER  = 8'hAB,
    parameter logic [7:0] FOOTER_MARKER  = 8'hCD,
    parameter int         TIMEOUT_CYCLES = 1024,
    localparam int        IDX_W          = $clog2(TOTAL_CLUSTERS)
) (
    input  logic                    b2b_clk,
    input  logic                    b2b_rst_n,
    input  logic [DATA_WIDTH-1:0]   cluster_data [TOTAL_CLUSTERS],
    input  logic [TOTAL_CLUSTERS-1:0] cluster_empty,
    output logic [TOTAL_CLUSTERS-1:0] cluster_req,
    output logic [DATA_WIDTH-1:0]   output_board_event,
    output logic                    output_board_wren,
    input  logic                    output_board_almost_full,
    output logic                    grant_valid,
    output logic [IDX_W-1:0]        grant_idx,
    output logic [31:0]             event_count,
    output logic                    err_no_header,
    output logic                    err_timeout
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, XFER} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic                  grant_valid_q, grant_valid_d;
    logic                  first_word_q, first_word_d;
    logic [DATA_WIDTH-1:0] event_q, event_d;
    logic                  wren_q, wren_d;
    logic [31:0]           count_q, count_d;
    logic                  err_nh_q, err_nh_d;
    logic                  err_to_q, err_to_d;
    logic [TO_W-1:0]       timeout_q, timeout_d;

    logic [DATA_WIDTH-1:0] head_word;
    logic [7:0]            head_marker;
    logic                  head_meta;
    logic                  is_header;
    logic                  is_footer;
    logic                  head_empty;
    logic                  pop;
    logic [IDX_W-1:0]      next_ptr;
    logic                  scan_win;
    logic [IDX_W-1:0]      scan_idx;
    logic [IDX_W:0]        scan_sum;

    assign head_word   = cluster_data[grant_idx_q];
    assign head_meta   = head_word[DATA_WIDTH-1];
    assign head_marker = head_word[DATA_WIDTH-2 -: 8];
    assign is_header   = head_meta && (head_marker == HEADER_MARKER);
    assign is_footer   = head_meta && (head_marker == FOOTER_MARKER);
    assign head_empty  = cluster_empty[grant_idx_q];
    assign pop         = (state_q == XFER) && !head_empty && !output_board_almost_full;
    assign next_ptr    = (grant_idx_q == IDX_W'(TOTAL_CLUSTERS - 1)) ? '0 : grant_idx_q + IDX_W'(1);

    // Rotating priority scan starting at rr_ptr; the sum wraps modulo the cluster count.
    always_comb begin
        scan_win = 1'b0;
        scan_idx = '0;
        scan_sum = '0;
        for (int i = 0; i < TOTAL_CLUSTERS; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (scan_sum >= (IDX_W+1)'(TOTAL_CLUSTERS)) begin
                scan_sum = scan_sum - (IDX_W+1)'(TOTAL_CLUSTERS);
            end
            if (!scan_win && !cluster_empty[scan_sum[IDX_W-1:0]]) begin
                scan_win = 1'b1;
                scan_idx = scan_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        cluster_req = '0;
        if (pop) begin
            cluster_req[grant_idx_q] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        first_word_d  = first_word_q;
        event_d       = event_q;
        wren_d        = 1'b0;
        count_d       = count_q;
        err_nh_d      = err_nh_q;
        err_to_d      = err_to_q;
        timeout_d     = timeout_q;

        case (state_q)
            IDLE: begin
                if (scan_win) begin
                    state_d       = XFER;
                    grant_idx_d   = scan_idx;
                    grant_valid_d = 1'b1;
                    first_word_d  = 1'b1;
                    timeout_d     = '0;
                end
            end
            XFER: begin
                if (pop) begin
                    event_d      = head_word;
                    wren_d       = 1'b1;
                    timeout_d    = '0;
                    first_word_d = 1'b0;
                    if (first_word_q && !is_header) begin
                        err_nh_d = 1'b1;
                    end
                    if (is_footer) begin
                        count_d       = count_q + 32'd1;
                        rr_ptr_d      = next_ptr;
                        state_d       = IDLE;
                        grant_valid_d = 1'b0;
                    end
                end else if (head_empty) begin
                    // Abandon the event on the TIMEOUT_CYCLES-th consecutive empty cycle.
                    if (timeout_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        err_to_d      = 1'b1;
                        rr_ptr_d      = next_ptr;
                        state_d       = IDLE;
                        grant_valid_d = 1'b0;
                        timeout_d     = '0;
                    end else begin
                        timeout_d = timeout_q + TO_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge b2b_clk or negedge b2b_rst_n) begin
        if (!b2b_rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            first_word_q  <= 1'b0;
            event_q       <= '0;
            wren_q        <= 1'b0;
            count_q       <= '0;
            err_nh_q      <= 1'b0;
            err_to_q      <= 1'b0;
            timeout_q     <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            first_word_q  <= first_word_d;
            event_q       <= event_d;
            wren_q        <= wren_d;
            count_q       <= count_d;
            err_nh_q      <= err_nh_d;
            err_to_q      <= err_to_d;
            timeout_q     <= timeout_d;
        end
    end

    assign output_board_event = event_q;
    assign output_board_wren  = wren_q;
    assign grant_valid        = grant_valid_q;
    assign grant_idx          = grant_idx_q;
    assign event_count        = count_q;
    assign err_no_header      = err_nh_q;
    assign err_timeout        = err_to_q;

endmodule

// File: tb/tb_b2b_event_arbiter.sv
// Randomized scoreboard bench for b2b_event_arbiter: cluster FIFOs are modelled as queues and
// the expected output stream comes from an event-level round-robin model.
module tb_b2b_event_arbiter;

    localparam int DW     = 65;
    localparam int NC     = 4;
    localparam int IW     = 2;
    localparam int TO_CYC = 1024;

    typedef logic [DW-1:0] word_t;

    logic          clk = 1'b0;
    logic          rst_n;
    word_t         cluster_data [NC];
    logic [NC-1:0] cluster_empty;
    logic [NC-1:0] cluster_req;
    word_t         obe;
    logic          wren;
    logic          af;
    logic          gv;
    logic [IW-1:0] gi;
    logic [31:0]   ecount;
    logic          errNh;
    logic          errTo;

    always #5 clk = ~clk;

    b2b_event_arbiter #(
        .DATA_WIDTH     (DW),
        .TOTAL_CLUSTERS (NC),
        .HEADER_MARKER  (8'hAB),
        .FOOTER_MARKER  (8'hCD),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .b2b_clk                  (clk),
        .b2b_rst_n                (rst_n),
        .cluster_data             (cluster_data),
        .cluster_empty            (cluster_empty),
        .cluster_req              (cluster_req),
        .output_board_event       (obe),
        .output_board_wren        (wren),
        .output_board_almost_full (af),
        .grant_valid              (gv),
        .grant_idx                (gi),
        .event_count              (ecount),
        .err_no_header            (errNh),
        .err_timeout              (errTo)
    );

    word_t         fifoQ [NC][$];
    word_t         expQ [$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [NC-1:0] popReq = '0;
    int            reqTotal = 0;
    int            wrenTotal = 0;
    int            lastWrenCyc = 0;
    int            runStart = 0;
    int            runLen = 0;
    logic          reqPrev = 1'b0;
    logic          afPrev = 1'b0;
    int            modelPtr = 0;
    int            modelEvents = 0;
    logic          randAf = 1'b0;
    logic          afHold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // kind: 0 = data word, 1 = header, 2 = footer
    function automatic word_t makeWord(input int kind);
        word_t w;
        w = {1'b0, $urandom, $urandom};
        if (kind == 1) begin
            w[DW-1] = 1'b1;
            w[DW-2 -: 8] = 8'hAB;
        end else if (kind == 2) begin
            w[DW-1] = 1'b1;
            w[DW-2 -: 8] = 8'hCD;
        end
        return w;
    endfunction

    function automatic logic allEmpty();
        logic e;
        e = 1'b1;
        for (int i = 0; i < NC; i++) begin
            if (fifoQ[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic refresh();
        for (int i = 0; i < NC; i++) begin
            cluster_empty[i] = (fifoQ[i].size() == 0);
            cluster_data[i]  = (fifoQ[i].size() == 0) ? '0 : fifoQ[i][0];
        end
    endtask

    // Advance one clock; the FIFO models pop whatever the DUT requested in the cycle just ended.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (popReq[i] && fifoQ[i].size() > 0) void'(fifoQ[i].pop_front());
        end
        refresh();
        af = randAf ? ($urandom_range(3, 0) == 0) : afHold;
    endtask

    // Load whole events into the cluster queues and derive the expected output order:
    // starting at the model pointer, repeatedly take the next non-empty cluster's oldest event.
    task automatic applyStimulus(input int evCnt [NC], input int minLen, input int maxLen,
                                 output int words, output int events);
        word_t pend [NC][$];
        int    lens [NC][$];
        word_t w;
        int    remaining;
        int    ptr;
        int    c;
        int    n;
        words  = 0;
        events = 0;
        for (int ci = 0; ci < NC; ci++) begin
            for (int e = 0; e < evCnt[ci]; e++) begin
                n = int'($urandom_range(maxLen, minLen));
                lens[ci].push_back(n);
                for (int k = 0; k < n; k++) begin
                    w = makeWord((k == 0) ? 1 : ((k == n - 1) ? 2 : 0));
                    pend[ci].push_back(w);
                    fifoQ[ci].push_back(w);
                end
                words  += n;
                events += 1;
            end
        end
        remaining = events;
        ptr = modelPtr;
        while (remaining > 0) begin
            for (int k = 0; k < NC; k++) begin
                c = (ptr + k) % NC;
                if (lens[c].size() > 0) begin
                    n = lens[c].pop_front();
                    repeat (n) expQ.push_back(pend[c].pop_front());
                    ptr = (c + 1) % NC;
                    remaining--;
                    break;
                end
            end
        end
        modelPtr = ptr;
        modelEvents += events;
        refresh();
    endtask

    task automatic waitDrain(input int budget);
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (expQ.size() == 0) && !gv && allEmpty();
        end
        checkOutput("drain_done", word_t'(done), word_t'(1));
    endtask

    task automatic waitWrens(input int count, input int budget);
        int n;
        int base;
        n = 0;
        base = wrenTotal;
        while ((wrenTotal - base) < count && n < budget) begin
            tick();
            n++;
        end
        checkOutput("wren_wait", word_t'((wrenTotal - base) >= count), word_t'(1));
    endtask

    // Scoreboard monitor: pops the expected stream on every write strobe and checks per-cycle rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            popReq  = '0;
            reqPrev = 1'b0;
            afPrev  = 1'b0;
        end else begin
            popReq = cluster_req;
            checkOutput("req_onehot", word_t'($onehot0(cluster_req)), word_t'(1));
            if (af) checkOutput("req_while_full", word_t'(cluster_req), word_t'(0));
            if (afPrev) checkOutput("wren_after_full", word_t'(wren), word_t'(0));
            if (cluster_req != '0) begin
                reqTotal++;
                if (!reqPrev) runStart = cyc;
                runLen = cyc - runStart + 1;
            end
            reqPrev = (cluster_req != '0);
            afPrev  = af;
            if (wren) begin
                wrenTotal++;
                lastWrenCyc = cyc;
                if (expQ.size() == 0) begin
                    checkOutput("spurious_wren", word_t'(expQ.size()), word_t'(1));
                end else begin
                    checkOutput("word", obe, expQ.pop_front());
                end
            end
        end
    end

    initial begin
        int    ev [NC];
        int    w;
        int    e;
        int    loadCyc;
        int    base;
        int    base2;
        int    dCyc;
        int    n;
        word_t h0;
        word_t d0;
        word_t d1;
        word_t f1;

        rst_n = 1'b0;
        af = 1'b0;
        refresh();
        repeat (3) tick();
        checkOutput("rst_grant_valid", word_t'(gv), word_t'(0));
        checkOutput("rst_grant_idx", word_t'(gi), word_t'(0));
        checkOutput("rst_req", word_t'(cluster_req), word_t'(0));
        checkOutput("rst_wren", word_t'(wren), word_t'(0));
        checkOutput("rst_event", obe, word_t'(0));
        checkOutput("rst_count", word_t'(ecount), word_t'(0));
        checkOutput("rst_err_nh", word_t'(errNh), word_t'(0));
        checkOutput("rst_err_to", word_t'(errTo), word_t'(0));
        rst_n = 1'b1;
        tick();

        $display("[TB] single event on cluster 0");
        ev = '{1, 0, 0, 0};
        loadCyc = cyc;
        base = reqTotal;
        base2 = wrenTotal;
        applyStimulus(ev, 5, 5, w, e);
        waitDrain(100);
        checkOutput("req_run_len", word_t'(runLen), word_t'(5));
        checkOutput("req_start_delay", word_t'(runStart - loadCyc), word_t'(1));
        checkOutput("req_cycles", word_t'(reqTotal - base), word_t'(5));
        checkOutput("wren_cycles", word_t'(wrenTotal - base2), word_t'(5));
        checkOutput("count_single", word_t'(ecount), word_t'(modelEvents));

        $display("[TB] two events per cluster, no backpressure");
        ev = '{2, 2, 2, 2};
        loadCyc = cyc;
        applyStimulus(ev, 3, 6, w, e);
        waitDrain(200);
        checkOutput("one_bubble_span", word_t'(lastWrenCyc - loadCyc), word_t'(w + e));
        checkOutput("count_rr", word_t'(ecount), word_t'(modelEvents));

        $display("[TB] almost_full held for 10 cycles mid-event");
        ev = '{0, 0, 1, 0};
        applyStimulus(ev, 16, 16, w, e);
        waitWrens(4, 50);
        af = 1'b1;
        afHold = 1'b1;
        base = reqTotal;
        base2 = wrenTotal;
        repeat (10) tick();
        afHold = 1'b0;
        af = 1'b0;
        checkOutput("req_during_full", word_t'(reqTotal - base), word_t'(0));
        checkOutput("wren_after_full_rise", word_t'((wrenTotal - base2) <= 1), word_t'(1));
        waitDrain(200);
        checkOutput("count_full", word_t'(ecount), word_t'(modelEvents));

        $display("[TB] random events with random backpressure");
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NC; i++) ev[i] = int'($urandom_range(2, 0));
            randAf = 1'b1;
            applyStimulus(ev, 2, 8, w, e);
            waitDrain(600);
            randAf = 1'b0;
            af = 1'b0;
            checkOutput("count_random", word_t'(ecount), word_t'(modelEvents));
        end

        $display("[TB] timeout on a stalled cluster");
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        modelPtr = 0;
        modelEvents = 0;
        h0 = makeWord(1);
        d0 = makeWord(0);
        fifoQ[0].push_back(h0);
        fifoQ[0].push_back(d0);
        expQ.push_back(h0);
        expQ.push_back(d0);
        for (int k = 0; k < 4; k++) begin
            w = k;
            d1 = makeWord((k == 0) ? 1 : ((k == 3) ? 2 : 0));
            fifoQ[1].push_back(d1);
            expQ.push_back(d1);
        end
        refresh();
        waitWrens(2, 20);
        dCyc = lastWrenCyc;
        n = 0;
        while (!errTo && n < TO_CYC + 100) begin
            tick();
            n++;
        end
        checkOutput("timeout_flag", word_t'(errTo), word_t'(1));
        checkOutput("timeout_latency", word_t'(cyc - dCyc), word_t'(TO_CYC));
        checkOutput("grant_after_timeout", word_t'(gv), word_t'(0));
        waitDrain(100);
        checkOutput("no_header_clean", word_t'(errNh), word_t'(0));
        checkOutput("count_after_timeout", word_t'(ecount), word_t'(1));
        d1 = makeWord(0);
        f1 = makeWord(2);
        fifoQ[0].push_back(d1);
        fifoQ[0].push_back(f1);
        expQ.push_back(d1);
        expQ.push_back(f1);
        refresh();
        waitDrain(100);
        checkOutput("no_header_flag", word_t'(errNh), word_t'(1));
        checkOutput("count_headless", word_t'(ecount), word_t'(2));
        checkOutput("timeout_sticky", word_t'(errTo), word_t'(1));

        $display("[TB] reset pulse mid-event");
        modelPtr = 1;
        ev = '{0, 0, 1, 0};
        applyStimulus(ev, 10, 10, w, e);
        waitWrens(3, 30);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_req", word_t'(cluster_req), word_t'(0));
        checkOutput("midrst_wren", word_t'(wren), word_t'(0));
        checkOutput("midrst_event", obe, word_t'(0));
        checkOutput("midrst_grant_valid", word_t'(gv), word_t'(0));
        checkOutput("midrst_grant_idx", word_t'(gi), word_t'(0));
        checkOutput("midrst_count", word_t'(ecount), word_t'(0));
        checkOutput("midrst_err_nh", word_t'(errNh), word_t'(0));
        checkOutput("midrst_err_to", word_t'(errTo), word_t'(0));
        for (int i = 0; i < NC; i++) fifoQ[i].delete();
        expQ.delete();
        refresh();
        tick();
        rst_n = 1'b1;
        modelPtr = 0;
        modelEvents = 0;
        ev = '{1, 0, 0, 1};
        applyStimulus(ev, 3, 6, w, e);
        waitDrain(100);
        checkOutput("count_after_reset", word_t'(ecount), word_t'(2));

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
